multi_core_dispatcher: RTL and testbench
========================================

MULTI_CORE_DISPATCHER -- requirements
Module: multi_core_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of SIMD cores served (2..16).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4: kernel queue entries (power of two, >=2).
REQ-003 SHALL have parameter KERNEL_W, default 40: kernel descriptor width in bits.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index first).
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL provide port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: reset.
REQ-008 SHALL provide port in_valid, input, 1 bit: a kernel descriptor is offered.
REQ-009 SHALL provide port in_kernel, input, KERNEL_W bits: the offered descriptor.
REQ-010 SHALL provide port in_ready, output, 1 bit: the queue can accept a descriptor.
REQ-011 SHALL provide port core_enable, input, NUM_CORES bits: a core may be selected only when its bit is 1.
REQ-012 SHALL provide port core_done, input, NUM_CORES bits: one-cycle pulse, core i has finished its warp.
REQ-013 SHALL provide port dispatch_valid, output, NUM_CORES bits: one-hot, one-cycle pulse, launch on core i.
REQ-014 SHALL provide port dispatch_kernel, output, KERNEL_W bits: descriptor accompanying dispatch_valid.
REQ-015 SHALL provide port core_busy, output, NUM_CORES bits: core i holds a dispatched, unfinished warp.
REQ-016 SHALL provide port queue_count, output, $clog2(QUEUE_DEPTH+1) bits: number of queued descriptors.
REQ-017 SHALL provide port idle, output, 1 bit: the queue is empty and no core is busy.

Function
REQ-018 SHALL drive in_ready = (queue_count < QUEUE_DEPTH) && !rst; there is no pass-through when the queue is full, even if a pop occurs in the same cycle.
REQ-019 SHALL push in_kernel at the rising edge where in_valid && in_ready; the write pointer wraps from QUEUE_DEPTH-1 to 0.
REQ-020 SHALL mark core i eligible in a cycle when core_busy[i]==0 and core_enable[i]==1; eligibility uses the registered core_busy.
REQ-021 SHALL, in a cycle with the queue non-empty and at least one core eligible, select exactly one eligible core and pop the queue head at the next edge.
REQ-022 SHALL register the selection: after that edge, dispatch_valid[sel]=1 for exactly one cycle, dispatch_kernel=popped head, core_busy[sel]=1.
REQ-023 SHALL hold dispatch_valid=0 and dispatch_kernel at its previous value in cycles with no dispatch.
REQ-024 SHALL achieve minimum latency of push at edge k -> dispatch_valid high in the cycle following edge k+1; throughput is at most one dispatch per cycle.
REQ-025 SHALL, when ARB_MODE=0, search eligible cores starting at rr_ptr and wrapping modulo NUM_CORES; after each grant, rr_ptr = (sel+1) mod NUM_CORES; rr_ptr is unchanged when there is no grant.
REQ-026 SHALL, when ARB_MODE=1, select the lowest-index eligible core.
REQ-027 SHALL clear core_busy[i] at the edge following core_done[i]=1; core_done on a non-busy core has no effect.
REQ-028 SHALL not select, in the cycle core_done[i] arrives, the core freed by that done; it becomes eligible one cycle later.
REQ-029 SHALL leave queue_count unchanged on a simultaneous push and pop; it never exceeds QUEUE_DEPTH and never underflows.
REQ-030 SHALL not clear core_busy when core_enable[i] is deasserted on a busy core; core_done still frees the core.
REQ-031 SHALL hold the queue and make no dispatch when all cores are disabled or busy.
REQ-032 SHALL derive idle combinationally from the registered state.

Reset
REQ-033 SHALL, on rst=1 at a rising edge: empty the queue, zero both pointers and queue_count, set core_busy=0, dispatch_valid=0, dispatch_kernel=0, rr_ptr=0.
REQ-034 SHALL, on reset mid-operation, discard queued descriptors, produce no dispatch in the cycle after the reset edge, and ignore in_valid while rst=1.

Verification
REQ-035 SHALL verify basic dispatch: NUM_CORES=4, ARB_MODE=0, all cores enabled, push descriptors A,B,C,D in consecutive cycles -> one-hot pulses on cores 0,1,2,3 in consecutive cycles with matching descriptors, core_busy=4'b1111.
REQ-036 SHALL verify full queue: all cores busy, push 5 descriptors -> in_ready=0 after the 4th, queue_count=4; core_done[2] -> next dispatch lands on core 2 with the oldest descriptor.
REQ-037 SHALL verify round-robin fairness: cores 0 and 2 free, rr_ptr=1, two descriptors queued -> core 2 then core 0; with ARB_MODE=1 -> core 0 then core 2.
REQ-038 SHALL verify same-cycle done and dispatch: core_done[1] while core 1 is busy and the queue is non-empty with no other core eligible -> no dispatch that cycle, then dispatch to core 1 one cycle later.
REQ-039 SHALL verify the enable mask: core_enable=4'b0101 -> dispatch only to cores 0 and 2; a third descriptor waits with queue_count=1.
REQ-040 SHALL verify reset mid-operation: 3 descriptors queued, 2 cores busy, rst=1 for one cycle -> queue_count=0, core_busy=0, idle=1, no dispatch_valid pulse after the reset edge.

Source files
------------

// File: rtl/multi_core_dispatcher.sv
// Kernel dispatcher: a descriptor FIFO feeding a pool of SIMD cores through a
// round-robin or fixed-priority arbiter, with per-core busy tracking.
module multi_core_dispatcher #(
   parameter int unsigned NUM_CORES   = 4,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned KERNEL_W    = 40,
   parameter int unsigned ARB_MODE    = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   input  logic [KERNEL_W-1:0]                in_kernel,
   output logic                               in_ready,
   input  logic [NUM_CORES-1:0]               core_enable,
   input  logic [NUM_CORES-1:0]               core_done,
   output logic [NUM_CORES-1:0]               dispatch_valid,
   output logic [KERNEL_W-1:0]                dispatch_kernel,
   output logic [NUM_CORES-1:0]               core_busy,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
   output logic                               idle
);

   localparam int unsigned IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int unsigned IDX_W1 = IDX_W + 1;
   localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);

   logic [KERNEL_W-1:0]  mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [IDX_W-1:0]     rr_ptr;
   logic [NUM_CORES-1:0] eligible;
   logic [NUM_CORES-1:0] grant;
   logic [IDX_W-1:0]     sel;
   logic [IDX_W-1:0]     rr_next;
   logic                 found;
   logic                 push;
   logic                 pop;

   // No pass-through: a full queue refuses input even if it pops this cycle.
   assign in_ready = (queue_count < CNT_W'(QUEUE_DEPTH)) && !rst;
   assign push     = in_valid && in_ready;
   assign eligible = ~core_busy & core_enable;
   assign pop      = (queue_count != '0) && found;
   assign grant    = pop ? (NUM_CORES'(1) << sel) : '0;
   assign rr_next  = (sel == IDX_W'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
   assign idle     = (queue_count == '0) && (core_busy == '0);

   // Core selection: first eligible core from rr_ptr (round robin) or from 0.
   always_comb begin
      logic [IDX_W1-1:0] cand;
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         if (ARB_MODE == 0) begin
            cand = {1'b0, rr_ptr} + IDX_W1'(k);
            if (cand >= IDX_W1'(NUM_CORES)) begin
               cand = cand - IDX_W1'(NUM_CORES);
            end
         end else begin
            cand = IDX_W1'(k);
         end
         if (!found && eligible[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            sel   = cand[IDX_W-1:0];
         end
      end
   end

   // Descriptor storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_kernel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         queue_count     <= '0;
         rr_ptr          <= '0;
         core_busy       <= '0;
         dispatch_valid  <= '0;
         dispatch_kernel <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr          <= rd_ptr + 1'b1;
            dispatch_kernel <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   queue_count <= queue_count + 1'b1;
            2'b01:   queue_count <= queue_count - 1'b1;
            default: ;
         endcase
         dispatch_valid <= grant;
         // Done on a core that is not busy is a no-op; a new grant wins.
         core_busy      <= (core_busy & ~core_done) | grant;
         if (pop && (ARB_MODE == 0)) begin
            rr_ptr <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_multi_core_dispatcher.sv
// Bench for multi_core_dispatcher: round-robin and fixed-priority instances
// share stimulus and are checked every cycle against a queue-based model.
module tb_multi_core_dispatcher;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int KW = 40;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [KW-1:0] in_kernel = '0;
   logic [N-1:0]  core_enable = '1;
   logic [N-1:0]  core_done = '0;

   logic          rdy0, rdy1, idle0, idle1;
   logic [N-1:0]  dv0, dv1, busy0, busy1;
   logic [KW-1:0] dk0, dk1;
   logic [2:0]    cnt0, cnt1;

   int total = 0;
   int bad   = 0;

   // Model state, index 0 = round robin, 1 = fixed priority.
   logic [KW-1:0] mq [2][16];
   int            mh [2];
   int            ms [2];
   int            mrr [2];
   logic [N-1:0]  mbusy [2];
   logic [N-1:0]  mdv [2];
   logic [KW-1:0] mdk [2];

   always #5 clk = ~clk;

   multi_core_dispatcher #(.NUM_CORES(N), .QUEUE_DEPTH(D), .KERNEL_W(KW), .ARB_MODE(0)) u_rr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_kernel(in_kernel), .in_ready(rdy0),
      .core_enable(core_enable), .core_done(core_done), .dispatch_valid(dv0),
      .dispatch_kernel(dk0), .core_busy(busy0), .queue_count(cnt0), .idle(idle0));

   multi_core_dispatcher #(.NUM_CORES(N), .QUEUE_DEPTH(D), .KERNEL_W(KW), .ARB_MODE(1)) u_fp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_kernel(in_kernel), .in_ready(rdy1),
      .core_enable(core_enable), .core_done(core_done), .dispatch_valid(dv1),
      .dispatch_kernel(dk1), .core_busy(busy1), .queue_count(cnt1), .idle(idle1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_update();
      for (int m = 0; m < 2; m++) begin
         int   g;
         logic pushm;
         if (rst) begin
            ms[m] = 0; mh[m] = 0; mrr[m] = 0;
            mbusy[m] = '0; mdv[m] = '0; mdk[m] = '0;
         end else begin
            pushm = in_valid && (ms[m] < D);
            g = -1;
            if (ms[m] > 0) begin
               for (int k = 0; k < N; k++) begin
                  int c;
                  c = (m == 0) ? (mrr[m] + k) % N : k;
                  if (g < 0 && !mbusy[m][c] && core_enable[c]) g = c;
               end
            end
            mbusy[m] = mbusy[m] & ~core_done;
            mdv[m] = '0;
            if (g >= 0) begin
               mdv[m][g]   = 1'b1;
               mbusy[m][g] = 1'b1;
               mdk[m]      = mq[m][mh[m]];
               mh[m]       = (mh[m] + 1) % 16;
               ms[m]       = ms[m] - 1;
               mrr[m]      = (g + 1) % N;
            end
            if (pushm) begin
               mq[m][(mh[m] + ms[m]) % 16] = in_kernel;
               ms[m] = ms[m] + 1;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("rr_dispatch_valid", 64'(dv0), 64'(mdv[0]));
      chk("rr_dispatch_kernel", 64'(dk0), 64'(mdk[0]));
      chk("rr_core_busy", 64'(busy0), 64'(mbusy[0]));
      chk("rr_queue_count", 64'(cnt0), 64'(ms[0]));
      chk("rr_in_ready", 64'(rdy0), 64'((ms[0] < D) && !rst));
      chk("rr_idle", 64'(idle0), 64'((ms[0] == 0) && (mbusy[0] == '0)));
      chk("fp_dispatch_valid", 64'(dv1), 64'(mdv[1]));
      chk("fp_dispatch_kernel", 64'(dk1), 64'(mdk[1]));
      chk("fp_core_busy", 64'(busy1), 64'(mbusy[1]));
      chk("fp_queue_count", 64'(cnt1), 64'(ms[1]));
      chk("fp_in_ready", 64'(rdy1), 64'((ms[1] < D) && !rst));
      chk("fp_idle", 64'(idle1), 64'((ms[1] == 0) && (mbusy[1] == '0)));
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic push_step(input logic [KW-1:0] k);
      in_valid  = 1'b1;
      in_kernel = k;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; core_done = '0; core_enable = '1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("reset_count", 64'(cnt0), 64'd0);
      chk("reset_idle", 64'(idle0), 64'd1);

      // Basic dispatch: A..D land on cores 0..3 in consecutive cycles.
      push_step(40'hA0A);
      push_step(40'hB0B);
      chk("basic_core0", 64'(dv0), 64'b0001);
      chk("basic_kernelA", 64'(dk0), 64'hA0A);
      push_step(40'hC0C);
      chk("basic_core1", 64'(dv0), 64'b0010);
      push_step(40'hD0D);
      chk("basic_core2", 64'(dv0), 64'b0100);
      step();
      chk("basic_core3", 64'(dv0), 64'b1000);
      chk("basic_kernelD", 64'(dk0), 64'hD0D);
      chk("basic_all_busy", 64'(busy0), 64'b1111);
      step();
      chk("basic_pulse_single", 64'(dv0), 64'd0);
      chk("basic_kernel_hold", 64'(dk0), 64'hD0D);

      // Full queue with all cores busy.
      for (int i = 1; i <= 5; i++) begin
         push_step(KW'(40'hE00 + i));
         if (i == 4) chk("full_in_ready", 64'(rdy0), 64'd0);
      end
      chk("full_count", 64'(cnt0), 64'd4);
      core_done = 4'b0100;
      step();
      core_done = '0;
      chk("full_done_no_dispatch", 64'(dv0), 64'd0);
      step();
      chk("full_core2", 64'(dv0), 64'b0100);
      chk("full_oldest", 64'(dk0), 64'hE01);

      // Round-robin vs fixed priority with cores 0,2 free and rr_ptr=1.
      do_reset();
      core_enable = 4'b1010;
      push_step(40'h111);
      push_step(40'h222);
      step();
      core_enable = 4'b0001;
      push_step(40'h333);
      step();
      core_enable = 4'b0000;
      core_done = 4'b0001;
      push_step(40'h0AA);
      core_done = '0;
      push_step(40'h0BB);
      chk("rr_setup_count", 64'(cnt0), 64'd2);
      core_enable = 4'b1111;
      step();
      chk("rr_first_core2", 64'(dv0), 64'b0100);
      chk("fp_first_core0", 64'(dv1), 64'b0001);
      step();
      chk("rr_second_core0", 64'(dv0), 64'b0001);
      chk("fp_second_core2", 64'(dv1), 64'b0100);
      chk("rr_second_kernel", 64'(dk0), 64'h0BB);

      // Same-cycle done and dispatch on core 1.
      do_reset();
      core_enable = 4'b0010;
      push_step(40'h5A1);
      step();
      push_step(40'h5A2);
      core_done = 4'b0010;
      step();
      core_done = '0;
      chk("done_same_cycle_none", 64'(dv0), 64'd0);
      step();
      chk("done_then_core1", 64'(dv0), 64'b0010);
      chk("done_then_kernel", 64'(dk0), 64'h5A2);

      // Enable mask 0101, then reset with work pending.
      do_reset();
      core_enable = 4'b0101;
      push_step(40'h701);
      push_step(40'h702);
      chk("mask_core0", 64'(dv0), 64'b0001);
      push_step(40'h703);
      chk("mask_core2", 64'(dv0), 64'b0100);
      step();
      chk("mask_wait", 64'(dv0), 64'd0);
      chk("mask_count", 64'(cnt0), 64'd1);
      push_step(40'h704);
      push_step(40'h705);
      chk("pre_reset_count", 64'(cnt0), 64'd3);
      chk("pre_reset_busy", 64'(busy0), 64'b0101);
      rst = 1'b1; in_valid = 1'b1; in_kernel = 40'h999;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("midrst_count", 64'(cnt0), 64'd0);
      chk("midrst_busy", 64'(busy0), 64'd0);
      chk("midrst_idle", 64'(idle0), 64'd1);
      step();
      chk("midrst_no_dispatch", 64'(dv0), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 63) == 0);
         in_valid    = ($urandom_range(0, 2) != 0);
         in_kernel   = KW'({$urandom(), $urandom()});
         core_enable = ($urandom_range(0, 5) == 0) ? N'($urandom()) : '1;
         core_done   = N'($urandom()) & N'($urandom());
         step();
      end
      rst = 1'b0; in_valid = 1'b0; core_done = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
